muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the register file and takes `ReadData1` (rs) and `ReadData2` (rt) as its operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles behind a start/busy/done handshake. It also services MTHI and MTLO writes, and presents HI/LO continuously for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4. HI and LO are each `WIDTH` bits.
- `Clk` input, 1 bit: clock, positive-edge triggered.
- `Reset_n` input, 1 bit: asynchronous, active-low reset. The block uses one clock; reset is asynchronous and active-low.
- `Start` input, 1 bit: launch the operation selected by `Op`. Sampled at the rising edge only when idle.
- `Op` input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `OperandA` input, `WIDTH` bits: rs. Multiplicand or dividend; also the data source for MTHI/MTLO.
- `OperandB` input, `WIDTH` bits: rt. Multiplier or divisor.
- `HiWrite` input, 1 bit: MTHI. HI is loaded from `OperandA`.
- `LoWrite` input, 1 bit: MTLO. LO is loaded from `OperandA`.
- `Busy` output, 1 bit: an operation is in progress.
- `Done` output, 1 bit: one-cycle pulse; HI/LO were just updated by an operation.
- `Hi` output, `WIDTH` bits: architectural HI.
- `Lo` output, `WIDTH` bits: architectural LO.

## Operation
- States: IDLE, RUN, FIXUP.
  - IDLE → RUN on `Start`.
  - RUN → FIXUP after `WIDTH` iterations, counted by an internal down-counter.
  - FIXUP → IDLE unconditionally.
- Operand load at `Start`: `OperandA`, `OperandB` and `Op` are captured into working registers. For signed ops, operands are converted to magnitudes and the result signs are recorded. Inputs may change after the `Start` edge.
- Multiply: unsigned shift-add, one multiplier bit per RUN cycle. The result is a 2·`WIDTH`-bit product.
- Divide: restoring shift-subtract, one quotient bit per RUN cycle. The result is a `WIDTH`-bit quotient and a `WIDTH`-bit remainder.
- FIXUP sign correction:
  - Signed product is negated when the operand signs differ.
  - Signed quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Result write on the FIXUP→IDLE edge:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- `Hi`/`Lo` do not change during RUN; working registers are separate from HI/LO.
- Divide by zero, signed or unsigned:
  - Takes the full latency.
  - LO = all ones, HI = dividend (`OperandA` unchanged).
  - Not an error; no flag.
- Signed overflow, -2^(W-1) / -1: LO = 0x80000000, HI = 0 (W=32).
- MTHI/MTLO: honoured only in IDLE with `Start` low; the target register is written at the next rising edge. Ignored while `Busy`, or when `Start` is high in the same cycle.
- `Start` while `Busy`: ignored, with no queuing.
- `Reset_n` low at any time, including mid-operation: the operation is discarded and the block returns to IDLE.

## Timing
- Reset values: state IDLE, `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, counter 0.
- `Start` sampled at edge 0. `Busy` rises after edge 0.
- RUN covers edges 1..`WIDTH`. FIXUP is the cycle after edge `WIDTH`.
- At edge `WIDTH`+1:
  - HI/LO are updated.
  - `Busy` falls.
  - `Done` is high for exactly that one cycle.
- Latency from the `Start` edge to the result edge is `WIDTH`+1 cycles (33 for `WIDTH`=32).
- Back-to-back operation: `Start` may be asserted in the cycle where `Done`=1; the new operation is accepted at the next edge.
- MTHI/MTLO: 1-cycle write. `Hi`/`Lo` reflect the new value after the edge.
- All outputs are registered; no combinational input→output path.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: DIV and DIVU are implemented as above.
  - Undefined: the divider datapath is compiled out. `Start` with `Op`=1x is ignored: state stays IDLE, `Busy` and `Done` stay 0, HI/LO are unchanged. Multiply behaviour and timing are identical either way.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: `Busy` is high 33 cycles, then `Done` pulses once with HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3 × 5: HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000: HI=0x40000000, LO=0.
- DIV -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 0: LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- `Start` MULTU 2×3, then `Start` again at cycle 5 with different operands, plus `HiWrite` at cycle 10: both ignored; result HI=0, LO=6.
- `Reset_n` pulsed low at cycle 15 of a DIVU: `Busy`/`Done`/`Hi`/`Lo` go to 0 immediately; no `Done` follows.
- In IDLE, `HiWrite` with `OperandA`=0x1234 then `LoWrite` with 0x5678: `Hi`=0x1234 and `Lo`=0x5678 after the respective edges. With `MULDIV_DIV_EN` undefined, `Start` DIV: `Busy` stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with architectural HI/LO registers for the
// MIPS datapath. Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring
// shift-subtract) over WIDTH+1 cycles behind a Start/Busy/Done handshake.
// It also services MTHI/MTLO and presents HI/LO continuously for MFHI/MFLO.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   : DIV/DIVU implemented
//   undefined : divider datapath removed, Start with Op=1x is ignored
//
// Ports
//   Clk       : clock, rising edge
//   Reset_n   : asynchronous active-low reset
//   Start     : launch Op (sampled only in IDLE)
//   Op        : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA  : rs - multiplicand/dividend, MTHI/MTLO data
//   OperandB  : rt - multiplier/divisor
//   HiWrite   : MTHI (IDLE with Start low only)
//   LoWrite   : MTLO (IDLE with Start low only)
//   Busy      : operation in progress
//   Done      : one-cycle pulse, HI/LO just written by an operation
//   Hi, Lo    : architectural HI/LO
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic             HiWrite,
   input  logic             LoWrite,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2
   } state_t;

   // Two's complement negation helpers
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   // wk_hi: partial product high half / partial remainder
   // wk_lo: multiplier being shifted out / dividend in, quotient out
   logic [WIDTH-1:0] wk_hi_q, wk_hi_d;
   logic [WIDTH-1:0] wk_lo_q, wk_lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             neg_q_q, neg_q_d;     // negate product / quotient
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q;
   logic             done_q;

   logic             op_signed_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic             op_ok_s;
   logic             accept_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [2*WIDTH-1:0] prod_s;

   assign op_signed_s = ~Op[0];
   assign a_neg_s     = op_signed_s & OperandA[WIDTH-1];
   assign b_neg_s     = op_signed_s & OperandB[WIDTH-1];
   assign a_mag_s     = a_neg_s ? neg_w(OperandA) : OperandA;
   assign b_mag_s     = b_neg_s ? neg_w(OperandB) : OperandB;

`ifdef MULDIV_DIV_EN
   assign op_ok_s = 1'b1;
`else
   assign op_ok_s = ~Op[1];
`endif

   assign accept_s = (state_q == S_IDLE) & Start & op_ok_s;

   // Shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift the whole {carry, hi, lo} chain right by one.
   assign mul_sum_s = {1'b0, wk_hi_q} + {1'b0, (wk_lo_q[0] ? b_q : {WIDTH{1'b0}})};

   assign prod_s = neg_q_q ? neg_2w({wk_hi_q, wk_lo_q}) : {wk_hi_q, wk_lo_q};

`ifdef MULDIV_DIV_EN
   logic             is_div_q, is_div_d;
   logic             neg_r_q, neg_r_d;     // remainder follows dividend sign
   logic             dz_q, dz_d;           // divisor was zero
   logic [WIDTH:0]   div_shift_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] div_diff_s;
   logic [WIDTH-1:0] quo_s;
   logic [WIDTH-1:0] rem_s;

   // Restoring step: shift next dividend bit into the partial remainder and
   // subtract the divisor when it fits. The difference is always < divisor,
   // so modulo-2^WIDTH arithmetic on the low bits is exact.
   assign div_shift_s = {wk_hi_q, wk_lo_q[WIDTH-1]};
   assign div_ge_s    = (div_shift_s >= {1'b0, b_q});
   assign div_diff_s  = div_shift_s[WIDTH-1:0] - b_q;

   // Divide by zero yields an all-ones quotient; the remainder path then
   // naturally reproduces the original dividend after sign restoration.
   assign quo_s = dz_q ? {WIDTH{1'b1}} : (neg_q_q ? neg_w(wk_lo_q) : wk_lo_q);
   assign rem_s = neg_r_q ? neg_w(wk_hi_q) : wk_hi_q;
`endif

   // Next-state, iteration datapath and architectural HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wk_hi_d = wk_hi_q;
      wk_lo_d = wk_lo_q;
      b_d     = b_q;
      neg_q_d = neg_q_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
      neg_r_d  = neg_r_q;
      dz_d     = dz_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = S_RUN;
               cnt_d   = CW'(WIDTH);
               wk_hi_d = {WIDTH{1'b0}};
               wk_lo_d = a_mag_s;
               b_d     = b_mag_s;
               neg_q_d = a_neg_s ^ b_neg_s;
`ifdef MULDIV_DIV_EN
               is_div_d = Op[1];
               neg_r_d  = a_neg_s;
               dz_d     = (OperandB == {WIDTH{1'b0}});
`endif
            end else if (!Start) begin
               if (HiWrite) begin
                  hi_d = OperandA;
               end else begin
                  hi_d = hi_q;
               end
               if (LoWrite) begin
                  lo_d = OperandA;
               end else begin
                  lo_d = lo_q;
               end
            end else begin
               // Start with a disabled op: nothing happens
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIXUP;
            end else begin
               state_d = S_RUN;
            end
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               wk_hi_d = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
               wk_lo_d = {wk_lo_q[WIDTH-2:0], div_ge_s};
            end else begin
               wk_hi_d = mul_sum_s[WIDTH:1];
               wk_lo_d = {mul_sum_s[0], wk_lo_q[WIDTH-1:1]};
            end
`else
            wk_hi_d = mul_sum_s[WIDTH:1];
            wk_lo_d = {mul_sum_s[0], wk_lo_q[WIDTH-1:1]};
`endif
         end
         S_FIXUP: begin
            state_d = S_IDLE;
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               hi_d = rem_s;
               lo_d = quo_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
`else
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, working and architectural registers; registered Busy/Done
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         wk_hi_q <= {WIDTH{1'b0}};
         wk_lo_q <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         neg_q_q <= 1'b0;
         hi_q    <= {WIDTH{1'b0}};
         lo_q    <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wk_hi_q <= wk_hi_d;
         wk_lo_q <= wk_lo_d;
         b_q     <= b_d;
         neg_q_q <= neg_q_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_q == S_FIXUP);
      end
   end

`ifdef MULDIV_DIV_EN
   // Divide-only control flags
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         is_div_q <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         is_div_q <= is_div_d;
         neg_r_q  <= neg_r_d;
         dz_q     <= dz_d;
      end
   end
`endif

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32): directed vector table,
// hand-written handshake/reset sequences and randomized operations checked
// against a plain-arithmetic reference model. Divide checks are built only
// when MULDIV_DIV_EN is defined; otherwise the ignored-divide behaviour is
// checked instead.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         Clk = 1'b0;
   logic         Reset_n;
   logic         Start;
   logic [1:0]   Op;
   logic [W-1:0] OperandA;
   logic [W-1:0] OperandB;
   logic         HiWrite;
   logic         LoWrite;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Hi;
   logic [W-1:0] Lo;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .Op       (Op),
      .OperandA (OperandA),
      .OperandB (OperandB),
      .HiWrite  (HiWrite),
      .LoWrite  (LoWrite),
      .Busy     (Busy),
      .Done     (Done),
      .Hi       (Hi),
      .Lo       (Lo)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: returns {HI, LO}
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] r64, q64, p64;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            p64 = 64'(sa * sb);
            return p64;
         end
         2'b01: begin
            p64 = {32'h0, a} * {32'h0, b};
            return p64;
         end
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sq  = sa / sb;
            sr  = sa % sb;
            q64 = 64'(sq);
            r64 = 64'(sr);
            return {r64[31:0], q64[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Launch at current negedge; returns at the negedge where Done is seen
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output int lat, output int busy_cnt);
      Start    = 1'b1;
      Op       = op;
      OperandA = a;
      OperandB = b;
      @(negedge Clk);
      Start    = 1'b0;
      Op       = 2'($urandom_range(0, 3));
      OperandA = $urandom;
      OperandB = $urandom;
      lat      = 0;
      busy_cnt = 0;
      while (Done !== 1'b1 && lat < 100) begin
         if (Busy === 1'b1) busy_cnt++;
         @(negedge Clk);
         lat++;
      end
      hi = Hi;
      lo = Lo;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hi, lo, a, b;
      logic [1:0]  op;
      logic [63:0] exp;
      int          lat, bc, seen_b, seen_d;

      Reset_n = 1'b0; Start = 1'b0; Op = 2'b00;
      OperandA = 32'h0; OperandB = 32'h0; HiWrite = 1'b0; LoWrite = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("reset busy", Busy, 1'b0);
      chk("reset done", Done, 1'b0);
      chk("reset hi", Hi, 32'h0);
      chk("reset lo", Lo, 32'h0);

      // MTHI / MTLO
      HiWrite = 1'b1; OperandA = 32'h1234;
      @(negedge Clk);
      HiWrite = 1'b0;
      chk("mthi hi", Hi, 32'h1234);
      chk("mthi lo untouched", Lo, 32'h0);
      LoWrite = 1'b1; OperandA = 32'h5678;
      @(negedge Clk);
      LoWrite = 1'b0;
      chk("mtlo lo", Lo, 32'h5678);
      chk("mtlo hi untouched", Hi, 32'h1234);

      // Directed vectors
      vq.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
      vq.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      vq.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
      vq.push_back('{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
      vq.push_back('{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
      vq.push_back('{2'b01, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000});
`ifdef MULDIV_DIV_EN
      vq.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vq.push_back('{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF});
      vq.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
      vq.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
      vq.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555});
      vq.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
`endif
      foreach (vq[i]) begin
         run_op(vq[i].op, vq[i].a, vq[i].b, hi, lo, lat, bc);
         chk($sformatf("vec%0d hi", i), hi, vq[i].hi);
         chk($sformatf("vec%0d lo", i), lo, vq[i].lo);
         chk($sformatf("vec%0d latency", i), lat, LAT);
         chk($sformatf("vec%0d busy cycles", i), bc, LAT);
         chk($sformatf("vec%0d busy low at done", i), Busy, 1'b0);
         @(negedge Clk);
         chk($sformatf("vec%0d done one cycle", i), Done, 1'b0);
      end

      // Back-to-back: second Start in the Done cycle
      run_op(2'b01, 32'd2, 32'd3, hi, lo, lat, bc);
      chk("b2b first lo", lo, 32'd6);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, hi, lo, lat, bc);
      chk("b2b second hi", hi, 32'hFFFF_FFFF);
      chk("b2b second lo", lo, 32'hFFFF_FFF1);
      chk("b2b second latency", lat, LAT);
      @(negedge Clk);

      // Start and MTHI while busy are ignored; HI stable during RUN
      HiWrite = 1'b1; OperandA = 32'hDEAD;
      @(negedge Clk);
      HiWrite = 1'b0;
      Start = 1'b1; Op = 2'b01; OperandA = 32'd2; OperandB = 32'd3;
      @(negedge Clk);
      Start = 1'b0;
      lat = 0;
      while (Done !== 1'b1 && lat < 100) begin
         @(negedge Clk);
         lat++;
         if (lat == 5) begin
            Start = 1'b1; Op = 2'b01; OperandA = 32'd7; OperandB = 32'd9;
         end else if (lat == 10) begin
            Start = 1'b0; HiWrite = 1'b1; OperandA = 32'hBEEF;
         end else begin
            Start = 1'b0; HiWrite = 1'b0;
         end
         if (lat == 12) chk("hi stable during run", Hi, 32'hDEAD);
      end
      Start = 1'b0; HiWrite = 1'b0;
      chk("ignore latency", lat, LAT);
      chk("ignore hi", Hi, 32'h0);
      chk("ignore lo", Lo, 32'd6);
      @(negedge Clk);
      chk("ignore no second op", Busy, 1'b0);
      chk("ignore done pulse", Done, 1'b0);

      // Reset in the middle of an operation
      HiWrite = 1'b1; LoWrite = 1'b1; OperandA = 32'hAAAA;
      @(negedge Clk);
      HiWrite = 1'b0; LoWrite = 1'b0;
`ifdef MULDIV_DIV_EN
      Start = 1'b1; Op = 2'b11; OperandA = 32'd1000; OperandB = 32'd7;
`else
      Start = 1'b1; Op = 2'b01; OperandA = 32'd1000; OperandB = 32'd7;
`endif
      @(negedge Clk);
      Start = 1'b0;
      repeat (14) @(negedge Clk);
      chk("busy before reset", Busy, 1'b1);
      Reset_n = 1'b0;
      #1;
      chk("midreset busy", Busy, 1'b0);
      chk("midreset done", Done, 1'b0);
      chk("midreset hi", Hi, 32'h0);
      chk("midreset lo", Lo, 32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      seen_d = 0;
      seen_b = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         if (Done === 1'b1) seen_d++;
         if (Busy === 1'b1) seen_b++;
      end
      chk("no done after reset", seen_d, 0);
      chk("no busy after reset", seen_b, 0);

`ifndef MULDIV_DIV_EN
      // Divider compiled out: DIV/DIVU starts are ignored
      HiWrite = 1'b1; OperandA = 32'h1111;
      @(negedge Clk);
      HiWrite = 1'b0; LoWrite = 1'b1; OperandA = 32'h2222;
      @(negedge Clk);
      LoWrite = 1'b0;
      Start = 1'b1; Op = 2'b10; OperandA = 32'd10; OperandB = 32'd3;
      @(negedge Clk);
      Op = 2'b11;
      @(negedge Clk);
      Start = 1'b0;
      seen_d = 0;
      seen_b = 0;
      for (int k = 0; k < 40; k++) begin
         if (Done === 1'b1) seen_d++;
         if (Busy === 1'b1) seen_b++;
         @(negedge Clk);
      end
      chk("nodiv busy", seen_b, 0);
      chk("nodiv done", seen_d, 0);
      chk("nodiv hi", Hi, 32'h1111);
      chk("nodiv lo", Lo, 32'h2222);
`endif

      // Randomized operations against the reference model
      for (int k = 0; k < 40; k++) begin
`ifdef MULDIV_DIV_EN
         op = 2'($urandom_range(0, 3));
`else
         op = 2'($urandom_range(0, 1));
`endif
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(op, a, b, hi, lo, lat, bc);
         exp = model(op, a, b);
         chk($sformatf("rand%0d op%0d a=%0h b=%0h hi", k, op, a, b), hi, exp[63:32]);
         chk($sformatf("rand%0d op%0d a=%0h b=%0h lo", k, op, a, b), lo, exp[31:0]);
         chk($sformatf("rand%0d latency", k), lat, LAT);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
